pll_lock_sequencer: RTL and testbench
=====================================

# pll_lock_sequencer

Reset and lock sequencer for the system rPLL. It runs on the free-running 27 MHz input clock and drives the PLL RESET pin. It qualifies the PLL LOCK output and produces a single "clocks ready" level that releases the DDR3, camera and TFT pipelines. It retries failed acquisitions, reports a hard failure, and can optionally reprogram the PLL's dynamic output phase (PSDA) at run time.

## Interface
Parameters:
- RST_CYCLES, 16: sys_clk cycles pll_reset is held high per attempt.
- LOCK_TIMEOUT, 27000: sys_clk cycles allowed for lock per attempt (1 ms).
- LOCK_STABLE, 256: consecutive cycles of synchronized lock required before ready.
- MAX_RETRY, 4: failed attempts before entering FAIL.
- SETTLE_CYCLES, 64: wait after a phase change before lock re-qualification.

Ports:
- sys_clk  in  1  27 MHz reference clock, the same clock that feeds the PLL CLKIN.
- sys_rst_n  in  1  asynchronous, active-low reset.
- pll_lock  in  1  PLL LOCK output; asynchronous to sys_clk.
- pll_reset  out  1  to PLL RESET; active high.
- clk_ready  out  1  high only in RUN; downstream reset release.
- lock_lost  out  1  one-cycle pulse when lock drops in RUN or SETTLE.
- pll_fail  out  1  sticky failure flag.
- retry_cnt  out  3  number of failed attempts in the current acquisition.
- phase_req  in  1  request a phase change; level, sampled in RUN only.
- phase_val  in  4  requested PSDA code.
- phase_ack  out  1  one-cycle pulse when phase_val is accepted.
- psda  out  4  to PLL PSDA.

## Operation
- pll_lock passes through a 2-flop synchronizer; the result is lock_s. All decisions use lock_s.
- One shared counter, cnt, is cleared on every state transition.
- States: HOLD, WAIT, STABLE, RUN, SETTLE, FAIL.
- HOLD: pll_reset=1. When cnt=RST_CYCLES-1, go to WAIT.
- WAIT: pll_reset=0.
  - If lock_s=1, go to STABLE.
  - Else if cnt=LOCK_TIMEOUT-1, increment retry_cnt. Go to FAIL if the new value equals MAX_RETRY, otherwise go to HOLD.
- STABLE: cnt counts while lock_s=1.
  - If lock_s=0, go to WAIT. retry_cnt does not change.
  - When cnt=LOCK_STABLE-1 with lock_s=1, go to RUN and clear retry_cnt.
- RUN: clk_ready=1.
  - If lock_s=0: pulse lock_lost, go to HOLD.
  - Else if phase_req=1 and PHASE_CTRL_EN is defined: latch psda<=phase_val, pulse phase_ack, go to SETTLE.
  - Lock loss has priority over phase_req.
- SETTLE: clk_ready=0.
  - If lock_s=0: pulse lock_lost, go to HOLD.
  - When cnt=SETTLE_CYCLES-1, go to STABLE.
- FAIL: pll_reset=1, pll_fail=1. Exit only through sys_rst_n.
- All outputs are registered. clk_ready is high exactly when state=RUN.
- psda holds its value across HOLD and retries; only sys_rst_n clears it.
- cnt is wide enough for max(LOCK_TIMEOUT, RST_CYCLES, LOCK_STABLE, SETTLE_CYCLES)-1. retry_cnt never exceeds MAX_RETRY; MAX_RETRY must be ≤7.

## Timing
- Reset values: state=HOLD, cnt=0, pll_reset=1, clk_ready=0, lock_lost=0, pll_fail=0, retry_cnt=0, phase_ack=0, psda=4'b0000.
- sys_rst_n assertion mid-operation immediately forces these values, including dropping clk_ready.
- First-attempt reset pulse: pll_reset is high for RST_CYCLES edges after sys_rst_n deasserts.
- Lock latency: let E be the edge that first samples pll_lock high while in WAIT. clk_ready rises after edge E+2+LOCK_STABLE, provided lock stays high.
- Lock loss in RUN: clk_ready falls, lock_lost pulses and pll_reset rises, all 3 edges after pll_lock falls (2 sync edges plus 1 registered edge).
- Phase change: psda updates on the same edge that phase_ack pulses and clk_ready falls. clk_ready returns SETTLE_CYCLES+LOCK_STABLE edges later.
- phase_req held high is re-accepted on every RUN entry. The requester drops phase_req on phase_ack.

## Configuration
- PHASE_CTRL_EN defined: the SETTLE state and phase handshake are built as described in Operation.
- PHASE_CTRL_EN undefined: SETTLE is omitted, phase_req and phase_val are ignored, phase_ack is held 0, and psda is held at 4'b0000.

## Test plan
Bench parameters: RST_CYCLES=4, LOCK_TIMEOUT=20, LOCK_STABLE=8, MAX_RETRY=2, SETTLE_CYCLES=6.
- Nominal: release reset, raise pll_lock 10 cycles later -> pll_reset high for 4 cycles, then clk_ready=1 at E+10, retry_cnt=0.
- Glitch in STABLE: lock high 5 cycles, low 1 cycle, high again -> return to WAIT, no retry increment, clk_ready at 8+2 cycles after the relock edge.
- Timeout and fail: pll_lock held 0 -> retry_cnt=1 after the first 20-cycle WAIT, second HOLD pulse, then pll_fail=1, pll_reset stuck high, retry_cnt=2.
- Loss in RUN: drop pll_lock -> lock_lost pulse and clk_ready=0 on the 3rd edge, new 4-cycle pll_reset pulse, ready again after relock.
- Phase (macro on): phase_req=1, phase_val=4'h5 in RUN -> psda=5 and one phase_ack pulse, clk_ready low for 6+8 cycles. Macro off: psda stays 0, phase_ack stays 0.
- Async reset during STABLE: assert sys_rst_n low -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/pll_lock_sequencer.sv
// -----------------------------------------------------------------------------
// pll_lock_sequencer
//
// Reset and lock sequencer for the system rPLL. The block runs on the
// free-running 27 MHz reference clock. It drives the PLL RESET pin and
// qualifies the PLL LOCK output. It produces a single "clocks ready" level
// that releases the downstream pipelines. Failed acquisitions are retried
// until a hard failure is flagged.
//
// Optional feature: define PHASE_CTRL_EN to build the run-time PSDA phase
// reprogramming path and its SETTLE state. With the macro undefined the
// phase inputs are ignored, phase_ack stays 0 and psda stays 4'b0000.
//
// Ports:
//   sys_clk    in   27 MHz reference clock (same clock as PLL CLKIN)
//   sys_rst_n  in   asynchronous active-low reset
//   pll_lock   in   PLL LOCK, asynchronous to sys_clk
//   pll_reset  out  PLL RESET, active high
//   clk_ready  out  high only while the sequencer is in RUN
//   lock_lost  out  one-cycle pulse when lock drops in RUN or SETTLE
//   pll_fail   out  sticky failure flag, cleared only by sys_rst_n
//   retry_cnt  out  failed attempts in the current acquisition
//   phase_req  in   phase change request (level, sampled in RUN)
//   phase_val  in   requested PSDA code
//   phase_ack  out  one-cycle pulse when phase_val is accepted
//   psda       out  PLL PSDA code
// -----------------------------------------------------------------------------
module pll_lock_sequencer #(
   parameter int unsigned RST_CYCLES    = 16,
   parameter int unsigned LOCK_TIMEOUT  = 27000,
   parameter int unsigned LOCK_STABLE   = 256,
   parameter int unsigned MAX_RETRY     = 4,
   parameter int unsigned SETTLE_CYCLES = 64
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic       pll_lock,
   output logic       pll_reset,
   output logic       clk_ready,
   output logic       lock_lost,
   output logic       pll_fail,
   output logic [2:0] retry_cnt,
   input  logic       phase_req,
   input  logic [3:0] phase_val,
   output logic       phase_ack,
   output logic [3:0] psda
);

   function automatic int unsigned max2(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

   // The counter must reach the largest terminal value, which is max-1.
   localparam int unsigned CNT_MAX = max2(max2(LOCK_TIMEOUT, RST_CYCLES),
                                          max2(LOCK_STABLE, SETTLE_CYCLES));
   localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYCLES - 1);
   localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
   localparam logic [CW-1:0] STABLE_LAST = CW'(LOCK_STABLE - 1);
   localparam logic [2:0]    RETRY_LIMIT = 3'(MAX_RETRY);

   typedef enum logic [2:0] {
      ST_HOLD   = 3'd0,
      ST_WAIT   = 3'd1,
      ST_STABLE = 3'd2,
      ST_RUN    = 3'd3,
      ST_FAIL   = 3'd5
`ifdef PHASE_CTRL_EN
      , ST_SETTLE = 3'd4
`endif
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    retry_cnt_q, retry_cnt_d;
   logic          sync1_q, sync2_q;
   logic          lock_s;
   logic          pll_reset_q, pll_reset_d;
   logic          clk_ready_q, clk_ready_d;
   logic          lock_lost_q, lock_lost_d;
   logic          pll_fail_q, pll_fail_d;
   logic          phase_ack_q, phase_ack_d;
   logic [3:0]    psda_q, psda_d;

`ifndef PHASE_CTRL_EN
   // Phase inputs have no function in this build.
   logic unused_phase_s;
   assign unused_phase_s = ^{phase_req, phase_val};
`endif

   assign lock_s = sync2_q;

   // Two-flop synchronizer for the asynchronous PLL LOCK signal.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= pll_lock;
         sync2_q <= sync1_q;
      end
   end

   // Next-state, counter, retry and output decode.
   always_comb begin
      state_d     = state_q;
      retry_cnt_d = retry_cnt_q;
      lock_lost_d = 1'b0;
      phase_ack_d = 1'b0;
      psda_d      = psda_q;
      cnt_d       = cnt_q;

      case (state_q)
         ST_HOLD: begin
            if (cnt_q == RST_LAST) begin
               state_d = ST_WAIT;
            end else begin
               state_d = ST_HOLD;
            end
         end
         ST_WAIT: begin
            if (lock_s) begin
               state_d = ST_STABLE;
            end else if (cnt_q == TIMEOUT_LAST) begin
               retry_cnt_d = retry_cnt_q + 3'd1;
               // >= keeps the count bounded even for a degenerate limit.
               if (retry_cnt_d >= RETRY_LIMIT) begin
                  state_d = ST_FAIL;
               end else begin
                  state_d = ST_HOLD;
               end
            end else begin
               state_d = ST_WAIT;
            end
         end
         ST_STABLE: begin
            if (!lock_s) begin
               state_d = ST_WAIT;
            end else if (cnt_q == STABLE_LAST) begin
               state_d     = ST_RUN;
               retry_cnt_d = 3'd0;
            end else begin
               state_d = ST_STABLE;
            end
         end
         ST_RUN: begin
            // Lock loss wins over a pending phase request.
            if (!lock_s) begin
               lock_lost_d = 1'b1;
               state_d     = ST_HOLD;
`ifdef PHASE_CTRL_EN
            end else if (phase_req) begin
               psda_d      = phase_val;
               phase_ack_d = 1'b1;
               state_d     = ST_SETTLE;
`endif
            end else begin
               state_d = ST_RUN;
            end
         end
`ifdef PHASE_CTRL_EN
         ST_SETTLE: begin
            if (!lock_s) begin
               lock_lost_d = 1'b1;
               state_d     = ST_HOLD;
            end else if (cnt_q == CW'(SETTLE_CYCLES - 1)) begin
               state_d = ST_STABLE;
            end else begin
               state_d = ST_SETTLE;
            end
         end
`endif
         ST_FAIL: begin
            state_d = ST_FAIL;
         end
         default: begin
            // Unused encodings recover through a fresh PLL reset.
            state_d = ST_HOLD;
         end
      endcase

      // One shared counter: cleared on any transition, idle in RUN and FAIL.
      if (state_d != state_q) begin
         cnt_d = '0;
      end else if ((state_q == ST_RUN) || (state_q == ST_FAIL)) begin
         cnt_d = cnt_q;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end

`ifndef PHASE_CTRL_EN
      psda_d = 4'b0000;
`endif

      // Outputs are decoded from the next state so they align with state_q.
      pll_reset_d = (state_d == ST_HOLD) || (state_d == ST_FAIL);
      clk_ready_d = (state_d == ST_RUN);
      pll_fail_d  = (state_d == ST_FAIL);
   end

   // State, counter and registered outputs.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q     <= ST_HOLD;
         cnt_q       <= '0;
         retry_cnt_q <= 3'd0;
         pll_reset_q <= 1'b1;
         clk_ready_q <= 1'b0;
         lock_lost_q <= 1'b0;
         pll_fail_q  <= 1'b0;
         phase_ack_q <= 1'b0;
         psda_q      <= 4'b0000;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         retry_cnt_q <= retry_cnt_d;
         pll_reset_q <= pll_reset_d;
         clk_ready_q <= clk_ready_d;
         lock_lost_q <= lock_lost_d;
         pll_fail_q  <= pll_fail_d;
         phase_ack_q <= phase_ack_d;
         psda_q      <= psda_d;
      end
   end

   assign pll_reset = pll_reset_q;
   assign clk_ready = clk_ready_q;
   assign lock_lost = lock_lost_q;
   assign pll_fail  = pll_fail_q;
   assign retry_cnt = retry_cnt_q;
   assign phase_ack = phase_ack_q;
   assign psda      = psda_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pll_lock_sequencer
//
// Self-checking bench for pll_lock_sequencer with RST_CYCLES=4,
// LOCK_TIMEOUT=20, LOCK_STABLE=8, MAX_RETRY=2, SETTLE_CYCLES=6.
// Each vector is one clock: inputs applied before edge n, outputs expected
// after edge n. Expected words go through a scoreboard queue and are popped
// when the cycle's outputs are sampled on the falling edge.
// Expected word layout: {pll_reset, clk_ready, lock_lost, pll_fail,
// retry_cnt[2:0], phase_ack, psda[3:0]}.
// -----------------------------------------------------------------------------
module tb_pll_lock_sequencer;

   logic       sys_clk   = 1'b0;
   logic       sys_rst_n = 1'b1;
   logic       pll_lock  = 1'b0;
   logic       phase_req = 1'b0;
   logic [3:0] phase_val = 4'h0;
   logic       pll_reset;
   logic       clk_ready;
   logic       lock_lost;
   logic       pll_fail;
   logic [2:0] retry_cnt;
   logic       phase_ack;
   logic [3:0] psda;

`ifdef PHASE_CTRL_EN
   localparam logic [3:0] PH  = 4'h5;
   localparam logic       ACK = 1'b1;
   localparam logic       RDY = 1'b0;
`else
   localparam logic [3:0] PH  = 4'h0;
   localparam logic       ACK = 1'b0;
   localparam logic       RDY = 1'b1;
`endif

   typedef struct {
      logic        lock;
      logic        req;
      logic [3:0]  val;
      logic [11:0] exp;
   } vec_t;

   vec_t        vecs[$];
   logic [11:0] exp_q[$];
   int          tests_run = 0;
   int          tests_failed = 0;

   pll_lock_sequencer #(
      .RST_CYCLES   (4),
      .LOCK_TIMEOUT (20),
      .LOCK_STABLE  (8),
      .MAX_RETRY    (2),
      .SETTLE_CYCLES(6)
   ) dut (
      .sys_clk  (sys_clk),
      .sys_rst_n(sys_rst_n),
      .pll_lock (pll_lock),
      .pll_reset(pll_reset),
      .clk_ready(clk_ready),
      .lock_lost(lock_lost),
      .pll_fail (pll_fail),
      .retry_cnt(retry_cnt),
      .phase_req(phase_req),
      .phase_val(phase_val),
      .phase_ack(phase_ack),
      .psda     (psda)
   );

   // 10-unit reference clock.
   always #5 sys_clk = ~sys_clk;

   // Global bound on run time.
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [11:0] px(input logic rst, input logic rdy, input logic lost,
                                      input logic fail, input logic [2:0] retry,
                                      input logic ack, input logic [3:0] ps);
      return {rst, rdy, lost, fail, retry, ack, ps};
   endfunction

   function automatic void add(input int n, input logic lock, input logic req,
                               input logic [3:0] val, input logic [11:0] e);
      vec_t v;
      v.lock = lock;
      v.req  = req;
      v.val  = val;
      v.exp  = e;
      for (int k = 0; k < n; k++) vecs.push_back(v);
   endfunction

   task automatic check(input string tag, input int idx, input logic [11:0] e);
      logic [11:0] got;
      got = {pll_reset, clk_ready, lock_lost, pll_fail, retry_cnt, phase_ack, psda};
      tests_run++;
      if (got !== e) begin
         tests_failed++;
         $display("FAIL %s[%0d]: rst/rdy/lost/fail/retry/ack/psda got %b %b %b %b %0d %b %h required %b %b %b %b %0d %b %h",
                  tag, idx, got[11], got[10], got[9], got[8], got[7:5], got[4], got[3:0],
                  e[11], e[10], e[9], e[8], e[7:5], e[4], e[3:0]);
      end
   endtask

   // Asynchronous reset mid-cycle; outputs must take reset values at once.
   task automatic do_reset(input string tag);
      #2;
      sys_rst_n = 1'b0;
      pll_lock  = 1'b0;
      phase_req = 1'b0;
      phase_val = 4'h0;
      #1;
      check({tag, "_async"}, 0, px(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 4'h0));
      repeat (2) @(posedge sys_clk);
      @(negedge sys_clk);
      check({tag, "_held"}, 0, px(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 4'h0));
      sys_rst_n = 1'b1;
   endtask

   task automatic run_vecs(input string tag);
      for (int i = 0; i < vecs.size(); i++) begin
         pll_lock  = vecs[i].lock;
         phase_req = vecs[i].req;
         phase_val = vecs[i].val;
         exp_q.push_back(vecs[i].exp);
         @(posedge sys_clk);
         @(negedge sys_clk);
         if (exp_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL %s[%0d]: scoreboard got empty queue required one entry", tag, i + 1);
         end else begin
            check(tag, i + 1, exp_q.pop_front());
         end
      end
      vecs.delete();
   endtask

   initial begin
      // Nominal acquisition (lock at edge 10, ready at edge 20), then loss in RUN.
      do_reset("por");
      add(3,  1'b0, 1'b0, 4'h0, px(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 4'h0));
      add(6,  1'b0, 1'b0, 4'h0, px(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 4'h0));
      add(10, 1'b1, 1'b0, 4'h0, px(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 4'h0));
      add(3,  1'b1, 1'b0, 4'h0, px(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 4'h0));
      add(2,  1'b0, 1'b0, 4'h0, px(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 4'h0));
      add(1,  1'b0, 1'b0, 4'h0, px(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 4'h0));
      add(3,  1'b0, 1'b0, 4'h0, px(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 4'h0));
      add(2,  1'b0, 1'b0, 4'h0, px(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 4'h0));
      add(10, 1'b1, 1'b0, 4'h0, px(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 4'h0));
      add(2,  1'b1, 1'b0, 4'h0, px(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 4'h0));
      run_vecs("nominal_loss");

      // Two timeouts with lock held low: retry to 1, then FAIL with retry 2.
      do_reset("from_run");
      add(3,  1'b0, 1'b0, 4'h0, px(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 4'h0));
      add(20, 1'b0, 1'b0, 4'h0, px(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 4'h0));
      add(4,  1'b0, 1'b0, 4'h0, px(1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 4'h0));
      add(20, 1'b0, 1'b0, 4'h0, px(1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 4'h0));
      add(5,  1'b0, 1'b0, 4'h0, px(1'b1, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 4'h0));
      add(4,  1'b1, 1'b0, 4'h0, px(1'b1, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 4'h0));
      run_vecs("timeout_fail");

      // One-cycle glitch in STABLE, phase change in RUN, loss, relock into STABLE.
      do_reset("from_fail");
      add(3,  1'b0, 1'b0, 4'h0, px(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 4'h0));
      add(1,  1'b0, 1'b0, 4'h0, px(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 4'h0));
      add(5,  1'b1, 1'b0, 4'h0, px(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 4'h0));
      add(1,  1'b0, 1'b0, 4'h0, px(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 4'h0));
      add(10, 1'b1, 1'b0, 4'h0, px(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 4'h0));
      add(2,  1'b1, 1'b0, 4'h0, px(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 4'h0));
      add(1,  1'b1, 1'b1, 4'h5, px(1'b0, RDY,  1'b0, 1'b0, 3'd0, ACK,  PH));
      add(13, 1'b1, 1'b0, 4'h0, px(1'b0, RDY,  1'b0, 1'b0, 3'd0, 1'b0, PH));
      add(2,  1'b1, 1'b0, 4'h0, px(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, PH));
      add(2,  1'b0, 1'b0, 4'h0, px(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, PH));
      add(1,  1'b0, 1'b0, 4'h0, px(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, PH));
      add(3,  1'b0, 1'b0, 4'h0, px(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, PH));
      add(2,  1'b0, 1'b0, 4'h0, px(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, PH));
      add(4,  1'b1, 1'b0, 4'h0, px(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, PH));
      run_vecs("glitch_phase");

      // Reset asserted while in STABLE; psda must also clear.
      do_reset("stable");

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
